// File: rtl/audio_sample_accumulator.sv
// rtl/audio_sample_accumulator.sv - groups multi-channel audio samples into HDMI audio-sample-packet payloads behind a packet FIFO

// Small packet queue; a push is accepted when not full, or when the head pops on the same edge.
module audio_packet_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_audio,
  input  logic             audio_buffer_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [2:0]       rd_ptr;
  logic [2:0]       wr_ptr;
  logic [3:0]       fill;
  logic             pop;
  logic             push_ok;

  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return (p == 3'(DEPTH - 1)) ? 3'd0 : p + 3'd1;
  endfunction

  assign head_valid = (fill != 4'd0);
  assign full       = (fill == 4'(DEPTH));
  assign pop        = head_valid && pop_ready;
  assign push_ok    = push && (!full || pop);

  // Present the entry at the read pointer; it only changes when the head pops.
  always_comb begin
    head_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_ptr == 3'(i)) head_data = mem[i];
    end
  end

  // Storage and pointer update; a full-FIFO push with pop overwrites the slot being vacated.
  always_ff @(posedge clk_audio or posedge audio_buffer_rst) begin
    if (audio_buffer_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= 3'd0;
      wr_ptr <= 3'd0;
      fill   <= 4'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok && (wr_ptr == 3'(i))) mem[i] <= push_data;
      end
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      fill <= fill + 4'(push_ok) - 4'(pop);
    end
  end

endmodule

// Sample collector: assembles up to MAX_SAMPLES_PER_PACKET samples, tags IEC block starts, queues packets.
module audio_sample_accumulator #(
  parameter int AUDIO_BIT_WIDTH        = 16,
  parameter int CHANNELS               = 2,
  parameter int MAX_SAMPLES_PER_PACKET = 4,
  parameter int DEPTH                  = 2
) (
  input  logic                                       clk_audio,
  input  logic                                       audio_buffer_rst,
  input  logic                                       sample_valid,
  input  logic [CHANNELS*AUDIO_BIT_WIDTH-1:0]        audio_sample_word,
  input  logic                                       packet_request,
  input  logic                                       packet_ready,
  output logic                                       packet_valid,
  output logic [MAX_SAMPLES_PER_PACKET*CHANNELS*24-1:0] packet_sample_word,
  output logic [MAX_SAMPLES_PER_PACKET-1:0]          packet_present,
  output logic [MAX_SAMPLES_PER_PACKET-1:0]          packet_start_of_block,
  output logic                                       packet_layout,
  output logic                                       overflow,
  output logic [7:0]                                 dropped_count
);

  localparam int MAXS   = MAX_SAMPLES_PER_PACKET;
  localparam int SLOT_W = CHANNELS * 24;
  localparam int PAY_W  = MAXS * SLOT_W;
  localparam int ENT_W  = PAY_W + 2 * MAXS;

  logic [2:0]        count;
  logic [2:0]        count_next;
  logic [7:0]        frame_index;
  logic [PAY_W-1:0]  asm_payload;
  logic [PAY_W-1:0]  asm_payload_next;
  logic [MAXS-1:0]   asm_sob;
  logic [MAXS-1:0]   asm_sob_next;
  logic [MAXS-1:0]   present_next;
  logic [SLOT_W-1:0] sample_just;
  logic              commit;
  logic              fifo_full;
  logic              drop;
  logic [ENT_W-1:0]  fifo_in;
  logic [ENT_W-1:0]  fifo_out;
  logic [8:0]        dropped_sum;

  assign packet_layout = (CHANNELS > 2) ? 1'b1 : 1'b0;

  // Left-justify every channel into a 24-bit container, low bits zero.
  always_comb begin
    sample_just = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sample_just[c*24 +: 24] = 24'(audio_sample_word[c*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]) << (24 - AUDIO_BIT_WIDTH);
    end
  end

  // Merge this cycle's sample into the assembly buffer and decide whether the packet closes now.
  always_comb begin
    asm_payload_next = asm_payload;
    asm_sob_next     = asm_sob;
    count_next       = count;
    present_next     = '0;
    for (int s = 0; s < MAXS; s++) begin
      if (sample_valid && (count == 3'(s))) begin
        asm_payload_next[s*SLOT_W +: SLOT_W] = sample_just;
        asm_sob_next[s]                      = (frame_index == 8'd0);
      end
    end
    if (sample_valid) count_next = count + 3'd1;
    for (int s = 0; s < MAXS; s++) begin
      present_next[s] = (3'(s) < count_next);
    end
    commit = (count_next == 3'(MAXS)) || (packet_request && (count_next != 3'd0));
  end

  assign fifo_in     = {asm_sob_next, present_next, asm_payload_next};
  assign drop        = commit && fifo_full && !(packet_valid && packet_ready);
  assign dropped_sum = {1'b0, dropped_count} + 9'(count_next);

  // Assembly state; a commit empties the buffer so unused slots of the next packet stay zero.
  always_ff @(posedge clk_audio or posedge audio_buffer_rst) begin
    if (audio_buffer_rst) begin
      count       <= 3'd0;
      asm_payload <= '0;
      asm_sob     <= '0;
    end else if (commit) begin
      count       <= 3'd0;
      asm_payload <= '0;
      asm_sob     <= '0;
    end else begin
      count       <= count_next;
      asm_payload <= asm_payload_next;
      asm_sob     <= asm_sob_next;
    end
  end

  // IEC 60958 block position advances on every captured sample, even ones later dropped.
  always_ff @(posedge clk_audio or posedge audio_buffer_rst) begin
    if (audio_buffer_rst) begin
      frame_index <= 8'd0;
    end else if (sample_valid) begin
      frame_index <= (frame_index == 8'd191) ? 8'd0 : frame_index + 8'd1;
    end
  end

  // Sticky overflow flag and saturating count of samples lost with dropped packets.
  always_ff @(posedge clk_audio or posedge audio_buffer_rst) begin
    if (audio_buffer_rst) begin
      overflow      <= 1'b0;
      dropped_count <= 8'd0;
    end else if (drop) begin
      overflow      <= 1'b1;
      dropped_count <= dropped_sum[8] ? 8'd255 : dropped_sum[7:0];
    end
  end

  audio_packet_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_packet_fifo (
    .clk_audio        (clk_audio),
    .audio_buffer_rst (audio_buffer_rst),
    .push             (commit),
    .push_data        (fifo_in),
    .pop_ready        (packet_ready),
    .head_valid       (packet_valid),
    .head_data        (fifo_out),
    .full             (fifo_full)
  );

  assign packet_sample_word    = fifo_out[PAY_W-1:0];
  assign packet_present        = fifo_out[PAY_W +: MAXS];
  assign packet_start_of_block = fifo_out[PAY_W+MAXS +: MAXS];

endmodule

// File: tb/tb_audio_sample_accumulator.sv
// tb/tb_audio_sample_accumulator.sv - directed self-checking bench for audio_sample_accumulator

module tb_audio_sample_accumulator;

  logic         clk_audio = 1'b0;
  logic         audio_buffer_rst;
  logic         sample_valid;
  logic [31:0]  audio_sample_word;
  logic         packet_request;
  logic         packet_ready;
  logic         packet_valid;
  logic [191:0] packet_sample_word;
  logic [3:0]   packet_present;
  logic [3:0]   packet_start_of_block;
  logic         packet_layout;
  logic         overflow;
  logic [7:0]   dropped_count;

  logic         s8_valid;
  logic [191:0] s8_word;
  logic         s8_request;
  logic         s8_ready;
  logic         p8_valid;
  logic [191:0] p8_word;
  logic [0:0]   p8_present;
  logic [0:0]   p8_sob;
  logic         p8_layout;
  logic         p8_overflow;
  logic [7:0]   p8_dropped;

  int n_checks = 0;
  int n_fail   = 0;
  int npkt;
  logic [191:0] w8a;
  logic [191:0] w8b;

  always #5 clk_audio = ~clk_audio;

  audio_sample_accumulator dut (
    .clk_audio             (clk_audio),
    .audio_buffer_rst      (audio_buffer_rst),
    .sample_valid          (sample_valid),
    .audio_sample_word     (audio_sample_word),
    .packet_request        (packet_request),
    .packet_ready          (packet_ready),
    .packet_valid          (packet_valid),
    .packet_sample_word    (packet_sample_word),
    .packet_present        (packet_present),
    .packet_start_of_block (packet_start_of_block),
    .packet_layout         (packet_layout),
    .overflow              (overflow),
    .dropped_count         (dropped_count)
  );

  audio_sample_accumulator #(
    .AUDIO_BIT_WIDTH        (24),
    .CHANNELS               (8),
    .MAX_SAMPLES_PER_PACKET (1),
    .DEPTH                  (2)
  ) dut8 (
    .clk_audio             (clk_audio),
    .audio_buffer_rst      (audio_buffer_rst),
    .sample_valid          (s8_valid),
    .audio_sample_word     (s8_word),
    .packet_request        (s8_request),
    .packet_ready          (s8_ready),
    .packet_valid          (p8_valid),
    .packet_sample_word    (p8_word),
    .packet_present        (p8_present),
    .packet_start_of_block (p8_sob),
    .packet_layout         (p8_layout),
    .overflow              (p8_overflow),
    .dropped_count         (p8_dropped)
  );

  task automatic check(input string tag, input logic [191:0] actual, input logic [191:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_audio);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic req);
    sample_valid      = 1'b1;
    audio_sample_word = w;
    packet_request    = req;
    step();
    sample_valid   = 1'b0;
    packet_request = 1'b0;
  endtask

  task automatic do_reset();
    audio_buffer_rst = 1'b1;
    step();
    audio_buffer_rst = 1'b0;
  endtask

  initial begin
    audio_buffer_rst  = 1'b1;
    sample_valid      = 1'b0;
    audio_sample_word = '0;
    packet_request    = 1'b0;
    packet_ready      = 1'b0;
    s8_valid          = 1'b0;
    s8_word           = '0;
    s8_request        = 1'b0;
    s8_ready          = 1'b0;
    step();
    do_reset();

    // reset state
    check("rst_valid", packet_valid, 0);
    check("rst_payload", packet_sample_word, 0);
    check("rst_present", packet_present, 0);
    check("rst_sob", packet_start_of_block, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dropped", dropped_count, 0);
    check("layout0", packet_layout, 0);
    check("layout1", p8_layout, 1);

    // four samples fill one packet
    send({16'h2222, 16'h1111}, 1'b0);
    send({16'h4444, 16'h3333}, 1'b0);
    send({16'h6666, 16'h5555}, 1'b0);
    check("no_pkt_at_3", packet_valid, 0);
    send({16'h8888, 16'h7777}, 1'b0);
    check("pkt4_valid", packet_valid, 1);
    check("pkt4_present", packet_present, 4'b1111);
    check("pkt4_sob", packet_start_of_block, 4'b0001);
    check("pkt4_slot0ch0", packet_sample_word[23:0], 24'h111100);
    check("pkt4_payload", packet_sample_word,
          {48'h888800_777700, 48'h666600_555500, 48'h444400_333300, 48'h222200_111100});
    step();
    check("pkt4_hold_valid", packet_valid, 1);
    check("pkt4_hold_payload", packet_sample_word[191:168], 24'h888800);
    packet_ready = 1'b1;
    step();
    packet_ready = 1'b0;
    check("pkt4_popped", packet_valid, 0);

    // request on the same edge as the 4th sample, then a 2-sample partial, then an empty request
    send(32'h0001_0002, 1'b0);
    send(32'h0003_0004, 1'b0);
    send(32'h0005_0006, 1'b0);
    send(32'h0007_0008, 1'b1);
    check("req4_valid", packet_valid, 1);
    check("req4_present", packet_present, 4'b1111);
    check("req4_sob", packet_start_of_block, 4'b0000);
    check("req4_slot3ch0", packet_sample_word[167:144], 24'h000800);
    packet_ready = 1'b1;
    step();
    packet_ready = 1'b0;
    send({16'hAAAA, 16'hBBBB}, 1'b0);
    send({16'hCCCC, 16'hDDDD}, 1'b0);
    packet_request = 1'b1;
    step();
    packet_request = 1'b0;
    check("req2_valid", packet_valid, 1);
    check("req2_present", packet_present, 4'b0011);
    check("req2_payload", packet_sample_word, {96'h0, 48'hCCCC00_DDDD00, 48'hAAAA00_BBBB00});
    packet_ready = 1'b1;
    step();
    packet_ready = 1'b0;
    packet_request = 1'b1;
    step();
    packet_request = 1'b0;
    check("req0_no_pkt", packet_valid, 0);
    step();
    check("req0_still_none", packet_valid, 0);

    // overflow: two packets queued, third dropped
    for (int k = 0; k < 12; k++) send({16'(16'h2000 + k), 16'(16'h1000 + k)}, 1'b0);
    check("ovf_flag", overflow, 1);
    check("ovf_dropped", dropped_count, 4);
    check("ovf_valid", packet_valid, 1);
    check("ovf_head", packet_sample_word[23:0], 24'h100000);
    for (int k = 12; k < 15; k++) send({16'(16'h2000 + k), 16'(16'h1000 + k)}, 1'b0);
    packet_ready = 1'b1;
    send({16'h200F, 16'h100F}, 1'b0);
    packet_ready = 1'b0;
    check("fullpop_dropped", dropped_count, 4);
    check("fullpop_head", packet_sample_word[23:0], 24'h100400);
    packet_ready = 1'b1;
    step();
    check("fullpop_new_head", packet_sample_word[23:0], 24'h100C00);
    check("fullpop_new_present", packet_present, 4'b1111);
    step();
    check("fullpop_drained", packet_valid, 0);
    packet_ready = 1'b0;

    // IEC block starts over 400 samples
    do_reset();
    packet_ready = 1'b1;
    npkt = 0;
    for (int i = 0; i < 400; i++) begin
      send(32'(i), 1'b0);
      if (packet_valid) begin
        check($sformatf("blk_sob_p%0d", npkt), packet_start_of_block,
              (npkt == 0 || npkt == 48 || npkt == 96) ? 4'b0001 : 4'b0000);
        npkt++;
      end
    end
    check("blk_pkt_count", npkt, 100);
    step();
    check("blk_drained", packet_valid, 0);
    check("blk_no_overflow", overflow, 0);
    packet_ready = 1'b0;

    // 8-channel, 24-bit, one sample per packet
    w8a = 192'h800001_700002_600003_500004_400005_300006_200007_100008;
    w8b = 192'h0A0A0A_0B0B0B_0C0C0C_0D0D0D_0E0E0E_0F0F0F_123456_654321;
    s8_valid = 1'b1;
    s8_word  = w8a;
    step();
    check("l1_valid", p8_valid, 1);
    check("l1_payload", p8_word, w8a);
    check("l1_present", p8_present, 1);
    check("l1_sob", p8_sob, 1);
    s8_word = w8b;
    step();
    s8_valid = 1'b0;
    check("l1_head_kept", p8_word, w8a);
    s8_ready = 1'b1;
    step();
    check("l1_second", p8_word, w8b);
    check("l1_second_sob", p8_sob, 0);
    step();
    s8_ready = 1'b0;
    check("l1_drained", p8_valid, 0);
    s8_request = 1'b1;
    step();
    s8_request = 1'b0;
    check("l1_req_ignored", p8_valid, 0);

    // reset mid-assembly with two packets queued
    for (int k = 0; k < 10; k++) send(32'(k), 1'b0);
    check("mid_queued", packet_valid, 1);
    audio_buffer_rst = 1'b1;
    #1;
    check("mid_rst_valid", packet_valid, 0);
    check("mid_rst_present", packet_present, 0);
    check("mid_rst_payload", packet_sample_word, 0);
    step();
    audio_buffer_rst = 1'b0;
    send({16'h0BB0, 16'h0AA0}, 1'b0);
    send({16'h0DD0, 16'h0CC0}, 1'b0);
    check("post_rst_partial", packet_valid, 0);
    send(32'h0, 1'b0);
    send(32'h0, 1'b0);
    check("post_rst_present", packet_present, 4'b1111);
    check("post_rst_sob", packet_start_of_block, 4'b0001);
    check("post_rst_slot0", packet_sample_word[47:0], 48'h0BB000_0AA000);
    check("post_rst_overflow", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_sample_accumulator.md
Name: audio_sample_accumulator

Overview:
- Audio-domain sample collector that groups incoming multi-channel samples into HDMI audio-sample-packet payloads.
- Supports layout 0 (2 ch, up to 4 samples per packet) and layout 1 (up to 8 ch, 1 sample per packet).
- Completed packets are queued in a DEPTH-entry FIFO for the packet scheduler (valid/ready), so capture never stalls while a packet waits to be sent.
- Tracks the IEC 60958 192-frame block position per sample and reports overflow.

Parameters:
- AUDIO_BIT_WIDTH, 16: sample width; legal 16..24.
- CHANNELS, 2: channels per sample; legal 2, 4, 6, 8.
- MAX_SAMPLES_PER_PACKET, 4: samples per packet; legal 1..4; must be 1 when CHANNELS>2.
- DEPTH, 2: FIFO packet slots; legal 1..8.

Ports:
- clk_audio  in  1  audio clock.
- audio_buffer_rst  in  1  reset; asynchronous, active-high; clock clk_audio.
- sample_valid  in  1  audio_sample_word holds a new sample this cycle.
- audio_sample_word  in  CHANNELS*AUDIO_BIT_WIDTH  channel 0 in LSBs.
- packet_request  in  1  close the partial packet now (scheduler slot available).
- packet_ready  in  1  consumer accepts the head packet.
- packet_valid  out  1  FIFO non-empty.
- packet_sample_word  out  MAX_SAMPLES_PER_PACKET*CHANNELS*24  head payload; slot 0, channel 0 in LSBs.
- packet_present  out  MAX_SAMPLES_PER_PACKET  per-slot sample-present bits.
- packet_start_of_block  out  MAX_SAMPLES_PER_PACKET  slot holds IEC frame index 0.
- packet_layout  out  1  constant: 1 when CHANNELS>2.
- overflow  out  1  sticky; a completed packet was dropped.
- dropped_count  out  8  saturating count of dropped samples.

Behaviour:
- Reset: count, FIFO pointers, frame_index, overflow, dropped_count = 0; packet_valid = 0; payload, present and start_of_block = 0. Reset is honoured at any time; a partially assembled packet and all queued packets are discarded.
- Assembly:
  - On each edge with sample_valid, the sample is written to slot count. Each channel is left-justified to 24 bits, with the low bits zero.
  - The slot's start_of_block bit = (frame_index == 0).
  - frame_index advances, wrapping 191 -> 0. It advances for every captured sample, including samples later dropped.
  - count_next = count + sample_valid.
- Commit:
  - Commit occurs on an edge where count_next == MAX_SAMPLES_PER_PACKET, or where packet_request && count_next > 0.
  - A sample arriving on the commit edge is included in the committed packet.
  - packet_request with count_next == 0 is ignored.
  - Committed entry: payload, present = (1<<count_next)-1, start_of_block. Unused slots are zero. count returns to 0.
- FIFO:
  - packet_valid and the head outputs are registered; a commit into an empty FIFO is visible on the cycle after the commit edge.
  - Pop on packet_valid && packet_ready.
  - Push and pop on the same edge are both honoured, including when the FIFO is full.
  - Commit when full and no pop: the entry is dropped, overflow is set, and dropped_count += count_next, saturating at 255.
  - Pop when empty has no effect.
  - Head outputs hold stable while packet_valid && !packet_ready.
- Layout 1 (MAX = 1): every accepted sample commits immediately; packet_request is irrelevant.

Test Plan:
- Defaults; 4 sample_valid pulses with words 0x1111/0x2222 … 0x7777/0x8888 -> one packet; present = 4'b1111; slot0 ch0 = 0x111100; start_of_block = 4'b0001; packet_valid high until packet_ready.
- 3 samples then packet_request on the same edge as a 4th sample -> present 4'b1111; packet_request alone after 2 samples -> present 4'b0011; packet_request with 0 samples -> no packet.
- DEPTH=2, packet_ready=0, 12 samples -> 2 packets queued, 3rd dropped; overflow = 1, dropped_count = 4. Commit on the same edge as a pop when full -> no drop.
- 400 samples with packet_ready=1 -> start_of_block set on samples 0, 192 and 384 only.
- CHANNELS=8, MAX=1, AUDIO_BIT_WIDTH=24 -> one packet per sample; packet_layout = 1; present = 1'b1.
- Assert audio_buffer_rst mid-assembly with 2 packets queued -> packet_valid = 0 immediately; next packet starts at frame index 0 with start_of_block = 1.
